// File: rtl/bsg_level_shift_iso_seq.sv
// Sequenced isolation/level-shift stage from the switchable v0 domain into always-on v1.
// Define BSG_LEVEL_SHIFT_ISO_HOLD_EN to hold the last registered data while clamped.
module bsg_level_shift_iso_seq #(
    parameter int unsigned width_p         = 16,
    parameter int unsigned channels_p      = 1,
    parameter int unsigned settle_cycles_p = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          iso_req_i,
    input  logic [channels_p-1:0]         ch_en_i,
    input  logic [channels_p-1:0]         v0_valid_i,
    input  logic [channels_p*width_p-1:0] v0_data_i,
    output logic [channels_p-1:0]         v1_valid_o,
    output logic [channels_p*width_p-1:0] v1_data_o,
    output logic                          iso_o
);

    localparam int unsigned DATA_W    = channels_p * width_p;
    localparam int unsigned CNT_W     = (settle_cycles_p < 1) ? 1 : $clog2(settle_cycles_p + 1);
    localparam bit          NO_SETTLE = (settle_cycles_p == 0);
    localparam logic [CNT_W-1:0] CNT_LAST = NO_SETTLE ? '0 : CNT_W'(settle_cycles_p - 1);

    typedef enum logic [1:0] {
        ST_ISO    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [channels_p-1:0]   valid_q, valid_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    iso_q, iso_d;
    logic                    pass;

    // Isolation sequencer: clamp while v0 is down, then wait out the settle interval.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_ISO: begin
                cnt_d = '0;
                if (!iso_req_i) begin
                    state_d = NO_SETTLE ? ST_ACTIVE : ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (iso_req_i) begin
                    state_d = ST_ISO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (iso_req_i) begin
                    state_d = ST_ISO;
                end
            end
            default: begin
                state_d = ST_ISO;
                cnt_d   = '0;
            end
        endcase
    end

    // Output stage: a clamp request in ACTIVE wins on the same edge.
    always_comb begin
        pass    = (state_q == ST_ACTIVE) && !iso_req_i;
        valid_d = '0;
`ifdef BSG_LEVEL_SHIFT_ISO_HOLD_EN
        data_d  = data_q;
`else
        data_d  = '0;
`endif
        for (int unsigned c = 0; c < channels_p; c++) begin
            if (pass && ch_en_i[c]) begin
                valid_d[c]                  = v0_valid_i[c];
                data_d[c*width_p +: width_p] = v0_data_i[c*width_p +: width_p];
            end
        end
        iso_d = (state_d != ST_ACTIVE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_ISO;
            cnt_q   <= '0;
            valid_q <= '0;
            data_q  <= '0;
            iso_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            iso_q   <= iso_d;
        end
    end

    assign v1_valid_o = valid_q;
    assign v1_data_o  = data_q;
    assign iso_o      = iso_q;

endmodule

// File: tb/tb_bsg_level_shift_iso_seq.sv
// Directed bench for bsg_level_shift_iso_seq: settle=3 main instance plus a settle=0 instance.
module tb_bsg_level_shift_iso_seq;

    localparam int unsigned W  = 16;
    localparam int unsigned CH = 2;
`ifdef BSG_LEVEL_SHIFT_ISO_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            iso_req;
    logic            iso_req0;
    logic [CH-1:0]   ch_en;
    logic [CH-1:0]   v0_valid;
    logic [CH*W-1:0] v0_data;
    logic [CH-1:0]   v1_valid, v1_valid0;
    logic [CH*W-1:0] v1_data, v1_data0;
    logic            iso, iso0;

    int checks   = 0;
    int failures = 0;

    bsg_level_shift_iso_seq #(.width_p(W), .channels_p(CH), .settle_cycles_p(3)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .iso_req_i(iso_req), .ch_en_i(ch_en),
        .v0_valid_i(v0_valid), .v0_data_i(v0_data),
        .v1_valid_o(v1_valid), .v1_data_o(v1_data), .iso_o(iso)
    );

    bsg_level_shift_iso_seq #(.width_p(W), .channels_p(CH), .settle_cycles_p(0)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .iso_req_i(iso_req0), .ch_en_i(ch_en),
        .v0_valid_i(v0_valid), .v0_data_i(v0_data),
        .v1_valid_o(v1_valid0), .v1_data_o(v1_data0), .iso_o(iso0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        iso_req  = 1'b1;
        iso_req0 = 1'b1;
        ch_en    = 2'b11;
        v0_valid = 2'b01;
        v0_data  = {16'h0000, 16'hA5A5};

        @(negedge clk);
        check("rst_iso",    32'(iso),       32'd1);
        check("rst_valid",  32'(v1_valid),  32'd0);
        check("rst_data",   v1_data,        32'd0);
        check("rst_iso0",   32'(iso0),      32'd1);

        // Release before edge 1
        rst_n    = 1'b1;
        iso_req  = 1'b0;
        iso_req0 = 1'b0;
        step();
        check("e1_iso",     32'(iso),       32'd1);
        check("e1_valid",   32'(v1_valid),  32'd0);
        check("e1_iso0",    32'(iso0),      32'd0);
        check("e1_valid0",  32'(v1_valid0), 32'd0);
        step();
        check("e2_iso",     32'(iso),       32'd1);
        check("e2_valid0",  32'(v1_valid0), 32'd1);
        check("e2_data0",   v1_data0,       32'h0000A5A5);
        step();
        check("e3_iso",     32'(iso),       32'd1);
        step();
        check("e4_iso",     32'(iso),       32'd0);
        check("e4_valid",   32'(v1_valid),  32'd0);
        check("e4_data",    v1_data,        32'd0);
        step();
        check("e5_valid",   32'(v1_valid),  32'd1);
        check("e5_data",    v1_data,        32'h0000A5A5);

        // Clamp entry from ACTIVE
        v0_data = {16'h0000, 16'h1234};
        step();
        check("act_valid",  32'(v1_valid),  32'd1);
        check("act_data",   v1_data,        32'h00001234);
        check("act_data0",  v1_data0,       32'h00001234);
        iso_req = 1'b1;
        step();
        check("clamp_iso",   32'(iso),      32'd1);
        check("clamp_valid", 32'(v1_valid), 32'd0);
        check("clamp_data",  v1_data,       HOLD ? 32'h00001234 : 32'd0);
        step();
        check("clamp2_valid", 32'(v1_valid), 32'd0);

        // Pulse during WAKE restarts the settle interval
        iso_req = 1'b0;
        step();
        check("wA_iso",     32'(iso),       32'd1);
        step();
        check("wA1_iso",    32'(iso),       32'd1);
        iso_req = 1'b1;
        step();
        check("wA2_iso",    32'(iso),       32'd1);
        iso_req = 1'b0;
        step();
        check("wB_iso",     32'(iso),       32'd1);
        step();
        check("wB1_iso",    32'(iso),       32'd1);
        step();
        check("wB2_iso",    32'(iso),       32'd1);
        check("wB2_valid",  32'(v1_valid),  32'd0);
        step();
        check("wB3_iso",    32'(iso),       32'd0);
        check("wB3_valid",  32'(v1_valid),  32'd0);
        step();
        check("wB4_valid",  32'(v1_valid),  32'd1);
        check("wB4_data",   v1_data,        32'h00001234);

        // Per-channel enable
        ch_en    = 2'b10;
        v0_valid = 2'b11;
        v0_data  = {16'h00FF, 16'hFFFF};
        step();
        check("en_valid",   32'(v1_valid),  32'd2);
        check("en_data",    v1_data,        HOLD ? 32'h00FF1234 : 32'h00FF0000);
        ch_en = 2'b11;
        step();
        check("en2_valid",  32'(v1_valid),  32'd3);
        check("en2_data",   v1_data,        32'h00FFFFFF);

        // Asynchronous reset between edges
        v0_valid = 2'b01;
        v0_data  = {16'h0000, 16'hBEEF};
        step();
        check("pre_rst_data",  v1_data,       32'h0000BEEF);
        check("pre_rst_valid", 32'(v1_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data",   v1_data,        32'd0);
        check("arst_valid",  32'(v1_valid),  32'd0);
        check("arst_iso",    32'(iso),       32'd1);
        check("arst_data0",  v1_data0,       32'd0);
        check("arst_iso0",   32'(iso0),      32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
